// File: rtl/cond_pkg.sv
// Shared types and constants for the conditional-execution unit.
package cond_pkg;

    // ARM condition-field encodings, in architectural order.
    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    // Bit positions of the flags inside an NZCV nibble.
    localparam int N_IDX = 3;
    localparam int Z_IDX = 2;
    localparam int C_IDX = 1;
    localparam int V_IDX = 0;

    typedef logic [3:0] flags_t;

endpackage : cond_pkg

// File: rtl/cond_eval.sv
// Purely combinational condition evaluator: condition field + NZCV -> pass/undef.
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  flags_t     flags,
    output logic       pass,
    output logic       undef
);

    logic n_flag;
    logic z_flag;
    logic c_flag;
    logic v_flag;

    assign n_flag = flags[N_IDX];
    assign z_flag = flags[Z_IDX];
    assign c_flag = flags[C_IDX];
    assign v_flag = flags[V_IDX];

    // Decode every encoding explicitly so NV resolves to a clean 0/1 pair.
    always_comb begin
        pass  = 1'b0;
        undef = 1'b0;
        case (cond_e'(cond))
            COND_EQ: pass = z_flag;
            COND_NE: pass = ~z_flag;
            COND_CS: pass = c_flag;
            COND_CC: pass = ~c_flag;
            COND_MI: pass = n_flag;
            COND_PL: pass = ~n_flag;
            COND_VS: pass = v_flag;
            COND_VC: pass = ~v_flag;
            COND_HI: pass = c_flag & ~z_flag;
            COND_LS: pass = ~c_flag | z_flag;
            COND_GE: pass = ~(n_flag ^ v_flag);
            COND_LT: pass = n_flag ^ v_flag;
            COND_GT: pass = ~z_flag & ~(n_flag ^ v_flag);
            COND_LE: pass = z_flag | (n_flag ^ v_flag);
            COND_AL: pass = 1'b1;
            COND_NV: begin
                pass  = 1'b0;
                undef = 1'b1;
            end
            default: begin
                pass  = 1'b0;
                undef = 1'b0;
            end
        endcase
    end

endmodule : cond_eval

// File: rtl/condlogic_pipe.sv
// Execute-stage conditional logic: condition check, flag register with
// save/restore, stall-aware M/W write-enable delay lines, status counters.
module condlogic_pipe
    import cond_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int WB_LAT  = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Stall,
    input  logic             Flush,
    input  logic             Valid,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             FlagSave,
    input  logic             FlagRestore,
    input  logic             ClrStatus,
    output logic             CondExE,
    output logic             PCSrcE,
    output logic             UndefE,
    output logic             MemWriteOut,
    output logic             RegWriteOut,
    output logic [3:0]       Flags,
    output logic             UndefSticky,
    output logic [CNT_W-1:0] ExecCnt,
    output logic [CNT_W-1:0] SquashCnt
);

    flags_t             flags_reg;
    flags_t             flags_next;
    flags_t             shadow_reg;
    logic [MEM_LAT-1:0] mem_line_reg;
    logic [MEM_LAT-1:0] mem_line_next;
    logic [WB_LAT-1:0]  wb_line_reg;
    logic [WB_LAT-1:0]  wb_line_next;
    logic [CNT_W-1:0]   exec_cnt_reg;
    logic [CNT_W-1:0]   squash_cnt_reg;
    logic               undef_sticky_reg;

    logic live;
    logic advance;
    logic cond_pass;
    logic cond_undef;
    logic mem_in;
    logic wb_in;

    assign live    = Valid & ~Flush;
    assign advance = ~Stall;

    // Condition is always judged against the registered flags, so a compare
    // immediately followed by a conditional instruction sees the new flags.
    cond_eval u_cond_eval (
        .cond  (Cond),
        .flags (flags_reg),
        .pass  (cond_pass),
        .undef (cond_undef)
    );

    assign CondExE = live & cond_pass;
    assign UndefE  = live & cond_undef;
    assign PCSrcE  = PCS & CondExE;

    assign mem_in = CondExE & MemW;
    assign wb_in  = CondExE & RegW;

    // Next flag value: restore wins outright, otherwise each group takes the
    // ALU result only for an executed instruction that requests it.
    always_comb begin
        flags_next = flags_reg;
        if (FlagRestore) begin
            flags_next = shadow_reg;
        end else begin
            if (CondExE & FlagW[1]) begin
                flags_next[N_IDX] = ALUFlags[N_IDX];
                flags_next[Z_IDX] = ALUFlags[Z_IDX];
            end
            if (CondExE & FlagW[0]) begin
                flags_next[C_IDX] = ALUFlags[C_IDX];
                flags_next[V_IDX] = ALUFlags[V_IDX];
            end
        end
    end

    // Architectural flags and shadow copy; save always captures the
    // pre-update value, which makes save+restore a swap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_reg  <= '0;
            shadow_reg <= '0;
        end else if (advance) begin
            flags_reg <= flags_next;
            if (FlagSave) begin
                shadow_reg <= flags_reg;
            end
        end
    end

    // Shift-register next-state: tap 0 takes the qualified enable, each later
    // tap takes its predecessor. Bubbles enter as 0 because mem_in/wb_in are
    // already gated by live.
    genvar gi;
    generate
        for (gi = 0; gi < MEM_LAT; gi++) begin : g_mem_line
            if (gi == 0) begin : g_head
                assign mem_line_next[gi] = mem_in;
            end else begin : g_tail
                assign mem_line_next[gi] = mem_line_reg[gi-1];
            end
        end
        for (gi = 0; gi < WB_LAT; gi++) begin : g_wb_line
            if (gi == 0) begin : g_head
                assign wb_line_next[gi] = wb_in;
            end else begin : g_tail
                assign wb_line_next[gi] = wb_line_reg[gi-1];
            end
        end
    endgenerate

    // Delay lines only move on advancing cycles so latency tracks the pipe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_line_reg <= '0;
            wb_line_reg  <= '0;
        end else if (advance) begin
            mem_line_reg <= mem_line_next;
            wb_line_reg  <= wb_line_next;
        end
    end

    // Saturating executed/squashed counters; clear acts even while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exec_cnt_reg   <= '0;
            squash_cnt_reg <= '0;
        end else if (ClrStatus) begin
            exec_cnt_reg   <= '0;
            squash_cnt_reg <= '0;
        end else if (advance & live) begin
            if (cond_pass) begin
                if (exec_cnt_reg != {CNT_W{1'b1}}) begin
                    exec_cnt_reg <= exec_cnt_reg + CNT_W'(1);
                end
            end else begin
                if (squash_cnt_reg != {CNT_W{1'b1}}) begin
                    squash_cnt_reg <= squash_cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    // Sticky record that an undefined condition reached execute.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            undef_sticky_reg <= 1'b0;
        end else if (ClrStatus) begin
            undef_sticky_reg <= 1'b0;
        end else if (advance & UndefE) begin
            undef_sticky_reg <= 1'b1;
        end
    end

    assign MemWriteOut = mem_line_reg[MEM_LAT-1];
    assign RegWriteOut = wb_line_reg[WB_LAT-1];
    assign Flags       = flags_reg;
    assign UndefSticky = undef_sticky_reg;
    assign ExecCnt     = exec_cnt_reg;
    assign SquashCnt   = squash_cnt_reg;

endmodule : condlogic_pipe

// File: doc/condlogic_pipe.md
Name: condlogic_pipe

Overview:
- Next-generation conditional-execution unit for the pipelined ARM core.
- Evaluates the 4-bit condition field against the architectural NZCV flags in the Execute stage and writes the flag registers per group.
- Delays the qualified MemWrite/RegWrite through stall-aware shift registers to the M and W stages.
- Also provides flag save/restore (exception entry/return), undefined-condition detection and saturating executed/squashed instruction counters.

Parameters:
- MEM_LAT, 1: Execute-to-memory delay of MemWriteOut in advancing cycles (>=1).
- WB_LAT, 2: Execute-to-writeback delay of RegWriteOut in advancing cycles (>=1).
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- Stall  in  1  holds the E slot and all internal pipeline/flag/counter state.
- Flush  in  1  squashes the E-stage instruction.
- Valid  in  1  an instruction occupies the E slot.
- Cond  in  4  condition field.
- ALUFlags  in  4  {N,Z,C,V} from the ALU.
- FlagW  in  2  [1] writes N,Z; [0] writes C,V.
- PCS  in  1  instruction writes the PC.
- RegW  in  1  instruction writes the register file.
- MemW  in  1  instruction writes memory.
- FlagSave  in  1  copy Flags to the shadow register.
- FlagRestore  in  1  copy the shadow register to Flags.
- ClrStatus  in  1  synchronous clear of counters and the sticky undef bit.
- CondExE  out  1  condition passed for a live E instruction (combinational).
- PCSrcE  out  1  PCS & CondExE (combinational).
- UndefE  out  1  live E instruction has Cond=4'b1111 (combinational).
- MemWriteOut  out  1  MemW qualified, delayed MEM_LAT.
- RegWriteOut  out  1  RegW qualified, delayed WB_LAT.
- Flags  out  4  architectural NZCV register.
- UndefSticky  out  1  set by any live undefined condition.
- ExecCnt  out  CNT_W  live instructions whose condition passed.
- SquashCnt  out  CNT_W  live instructions whose condition failed.

Behaviour:
- Reset (reset=0, asynchronous) clears all of: Flags, shadow, both delay lines, ExecCnt, SquashCnt and UndefSticky.
- live = Valid & ~Flush. All combinational outputs are 0 when live=0.
- Conditions:
  - EQ..LE use the standard ARM encodings on the registered Flags.
  - AL (1110) always passes.
  - 1111 (NV/undefined): CondExE=0 and UndefE=1. Never X.
- Advance = ~Stall. When Stall=1, every register holds. PCSrcE remains combinational and is still driven.
- Flag update on an advancing cycle, in priority order:
  - FlagRestore: Flags<=shadow. A simultaneous ALU flag write is discarded.
  - Otherwise, per group g: if live & CondExE & FlagW[g], the group takes ALUFlags.
- FlagSave on an advancing cycle: shadow<=pre-update Flags.
- FlagSave and FlagRestore together perform a swap: Flags<=shadow and shadow<=old Flags.
- Delay lines:
  - Each advancing cycle shifts in live&CondExE&MemW (mem line) and live&CondExE&RegW (wb line).
  - Flushed or invalid slots shift in 0 as a bubble.
  - Outputs are the last tap. Latency is counted in advancing cycles only.
- Counters: on an advancing, live cycle, either ExecCnt or SquashCnt increments. Undefined conditions count as squashed.
  - Each counter saturates at 2^CNT_W-1 with no wrap.
  - ClrStatus (advancing or not) zeroes both counters and UndefSticky. It has priority over an increment in the same cycle.
- UndefSticky sets on an advancing live undefined condition and clears only via ClrStatus or reset.
- Flags visible to an instruction are those registered before its E cycle, so back-to-back CMP/Bcc needs no forwarding.

Decomposition:
- cond_pkg holds:
  - cond_e enum of 4 bits: EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE,AL,NV.
  - Flag index constants N_IDX=3, Z_IDX=2, C_IDX=1, V_IDX=0.
  - typedef flags_t of 4 bits.
- One sub-module, cond_eval: combinational Cond/Flags -> pass and undef outputs.
- The delay lines are generate loops in the top module.

Test Plan:
- Reset, then Cond=EQ, Flags=0, RegW=1 -> CondExE=0, SquashCnt=1. RegWriteOut stays 0 for 2 cycles.
- ALUFlags=4'b0100 with FlagW=2'b10, then Cond=EQ with MemW=1 -> Flags=4'b0100, CondExE=1. MemWriteOut=1 exactly 1 cycle later.
- Same as the previous case with Stall=1 for 3 cycles between E and M -> MemWriteOut is delayed to cycle 4, Flags are unchanged during the stall, and ExecCnt increments once.
- Cond=AL with Flush=1, PCS=1 -> PCSrcE=0, a bubble is shifted in, and neither counter changes.
- Flags=4'b1001: FlagSave; later write Flags=4'b0110; then FlagSave+FlagRestore together -> Flags=4'b1001 and shadow=4'b0110.
- Cond=4'b1111 live -> UndefE=1, UndefSticky=1, CondExE=0. Preload SquashCnt to 16'hFFFF and issue another squash -> it stays 16'hFFFF. ClrStatus -> both counters and UndefSticky read 0.
